// File: rtl/nr_sqrt_stream.sv
// Streaming unsigned integer square root using a non-restoring, add-only
// digit recurrence: one root bit per cycle, then a single correction cycle.
module nr_sqrt_stream #(
   parameter  int NBITS     = 16,
   parameter  int FRAC_BITS = 0,
   parameter  int TAG_BITS  = 1,
   localparam int QW        = NBITS / 2 + FRAC_BITS,
   localparam int RW        = QW + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [NBITS-1:0]    in_data_i,
   input  logic [TAG_BITS-1:0] in_tag_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [QW-1:0]       out_root_o,
   output logic [RW-1:0]       out_rem_o,
   output logic [TAG_BITS-1:0] out_tag_o,
   output logic                busy_o
);

   localparam int CW = $clog2(QW + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t              state;
   logic [NBITS-1:0]    rad;
   logic [RW:0]         r;
   logic [QW-1:0]       q;
   logic [CW-1:0]       cnt;
   logic [TAG_BITS-1:0] tag;
   logic                take;
   logic [RW:0]         r_step;
   logic [RW:0]         r_fix;

   // NOTE: in_ready depends combinationally on out_ready_i so a finished result
   // can be drained and the next radicand accepted on the same edge.
   assign in_ready_o = ~rst_i & ((state == IDLE) | ((state == DONE) & out_ready_i));
   assign take       = in_valid_i & in_ready_o;
   assign busy_o     = (state != IDLE);

   // The sign of R selects +{Q,11} or -{Q,01}; both are formed as one addend.
   assign r_step = {r[RW-2:0], rad[NBITS-1 -: 2]} + {q ^ {QW{~r[RW]}}, 2'b11};
   assign r_fix  = r[RW] ? r + {1'b0, q, 1'b1} : r;

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values, regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         rad         <= '0;
         r           <= '0;
         q           <= '0;
         cnt         <= '0;
         tag         <= '0;
         out_valid_o <= 1'b0;
         out_root_o  <= '0;
         out_rem_o   <= '0;
         out_tag_o   <= '0;
      end else if (take) begin
         // Only reachable from IDLE or from DONE while the result is drained.
         state       <= RUN;
         rad         <= in_data_i;
         tag         <= in_tag_i;
         r           <= '0;
         q           <= '0;
         cnt         <= CW'(QW);
         out_valid_o <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               r   <= r_step;
               q   <= QW'({q, ~r_step[RW]});
               rad <= rad << 2;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= FIX;
            end
            FIX: begin
               r           <= r_fix;
               out_root_o  <= q;
               out_rem_o   <= r_fix[RW-1:0];
               out_tag_o   <= tag;
               out_valid_o <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nr_sqrt_stream.sv
// Self-checking bench for nr_sqrt_stream: an integer-root instance and a
// 4-fractional-bit instance, checked against a floating-point sqrt model.
module tb_nr_sqrt_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_valid, in_ready, out_valid, out_ready, busy;
   logic [15:0] in_data;
   logic [3:0]  in_tag;
   logic [7:0]  root0;
   logic [8:0]  rem0;
   logic [3:0]  tag0;
   logic [11:0] root1;
   logic [12:0] rem1;
   logic [3:0]  tag1;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] stim[$];

   typedef struct {
      longint unsigned root;
      longint unsigned rem;
      logic [3:0]      tag;
   } exp_t;

   always #5 clk = ~clk;

   nr_sqrt_stream #(.NBITS(16), .FRAC_BITS(0), .TAG_BITS(4)) u_dut0 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
      .in_data_i(in_data), .in_tag_i(in_tag),
      .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
      .out_root_o(root0), .out_rem_o(rem0), .out_tag_o(tag0),
      .busy_o(busy[0])
   );

   nr_sqrt_stream #(.NBITS(16), .FRAC_BITS(4), .TAG_BITS(4)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
      .in_data_i(in_data), .in_tag_i(in_tag),
      .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
      .out_root_o(root1), .out_rem_o(rem1), .out_tag_o(tag1),
      .busy_o(busy[1])
   );

   task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic longint unsigned get_root(input bit sel);
      return sel ? 64'(root1) : 64'(root0);
   endfunction

   function automatic longint unsigned get_rem(input bit sel);
      return sel ? 64'(rem1) : 64'(rem0);
   endfunction

   function automatic longint unsigned get_tag(input bit sel);
      return sel ? 64'(tag1) : 64'(tag0);
   endfunction

   // Reference: floor(sqrt(d * 4^F)) via real sqrt, nudged to the exact integer.
   function automatic void model(input bit sel, input logic [15:0] d,
                                 output longint unsigned r, output longint unsigned m);
      longint unsigned x;
      x = 64'(d) << (sel ? 8 : 0);
      r = longint'($rtoi($sqrt(real'(x))));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      m = x - r * r;
   endfunction

   // Counts edges from an accept edge (already counted in lat) to out_valid.
   task automatic wait_result(input bit sel, inout int lat);
      while (!out_valid[sel] && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!out_valid[sel]) check("result_timeout", 64'(out_valid[sel]), 1);
   endtask

   task automatic run_op(input bit sel, input logic [15:0] d, input logic [3:0] t, output int lat);
      int b;
      @(negedge clk);
      in_valid[sel] = 1'b1;
      in_data       = d;
      in_tag        = t;
      b = 0;
      while (!in_ready[sel] && b < 100) begin
         @(negedge clk);
         b++;
      end
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid[sel] = 1'b0;
      wait_result(sel, lat);
   endtask

   task automatic stream(input bit sel, input int n, input bit bp, output int gap);
      exp_t exp_q[$];
      int   t_first[$];
      gap = -1;
      fork
         begin : drive
            logic [15:0] d;
            logic [3:0]  t;
            int          b;
            exp_t        e;
            for (int i = 0; i < n; i++) begin
               d = (stim.size() > 0) ? stim.pop_front() : 16'($urandom);
               t = 4'($urandom);
               @(negedge clk);
               #1;
               in_valid[sel] = 1'b1;
               in_data       = d;
               in_tag        = t;
               b = 0;
               while (!in_ready[sel] && b < 500) begin
                  @(negedge clk);
                  #1;
                  b++;
               end
               if (b >= 500) begin
                  check("accept_timeout", 0, 1);
                  break;
               end
               model(sel, d, e.root, e.rem);
               e.tag = t;
               exp_q.push_back(e);
               @(posedge clk);
            end
            @(negedge clk);
            #1;
            in_valid[sel] = 1'b0;
         end
         begin : watch
            int   got = 0;
            int   cyc = 0;
            exp_t e;
            while (got < n && cyc < n * 40 + 200) begin
               @(negedge clk);
               out_ready[sel] = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
               if (out_valid[sel] && out_ready[sel]) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_result", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     check("stream_root", get_root(sel), e.root);
                     check("stream_rem", get_rem(sel), e.rem);
                     check("stream_tag", get_tag(sel), 64'(e.tag));
                  end
                  if (t_first.size() < 2) t_first.push_back(cyc);
                  got++;
               end
               cyc++;
            end
            check("stream_count", 64'(got), 64'(n));
         end
      join
      if (t_first.size() >= 2) gap = t_first[1] - t_first[0];
      out_ready[sel] = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int              lat, gap, b, seen;
      longint unsigned er, em;

      rst       = 1'b1;
      in_valid  = 2'b00;
      out_ready = 2'b11;
      in_data   = '0;
      in_tag    = '0;

      #2;
      for (int s = 0; s < 2; s++) begin
         check("rst_valid", 64'(out_valid[s]), 0);
         check("rst_busy", 64'(busy[s]), 0);
         check("rst_ready", 64'(in_ready[s]), 0);
         check("rst_root", get_root(1'(s)), 0);
         check("rst_rem", get_rem(1'(s)), 0);
         check("rst_tag", get_tag(1'(s)), 0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 64'(in_ready), 3);

      // Basic integer root and latency
      run_op(1'b0, 16'd144, 4'd5, lat);
      check("lat_144", 64'(lat), 10);
      check("root_144", get_root(1'b0), 12);
      check("rem_144", get_rem(1'b0), 0);
      check("tag_144", get_tag(1'b0), 5);

      // Fractional root: sqrt(2) with 4 fraction bits
      run_op(1'b1, 16'd2, 4'd6, lat);
      check("lat_frac", 64'(lat), 14);
      check("root_frac", get_root(1'b1), 22);
      check("rem_frac", get_rem(1'b1), 28);
      check("tag_frac", get_tag(1'b1), 6);

      // Zero then all-ones back to back
      stim = '{16'd0, 16'hFFFF};
      stream(1'b0, 2, 1'b0, gap);
      check("b2b_gap", 64'(gap), 10);
      model(1'b0, 16'hFFFF, er, em);
      check("model_ones_root", er, 255);
      check("model_ones_rem", em, 510);

      // Back-pressure: result held, new radicand waiting with in_valid high
      out_ready[0] = 1'b0;
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data     = 16'd40001;
      in_tag      = 4'd3;
      @(posedge clk);
      @(negedge clk);
      in_data = 16'd50;
      in_tag  = 4'd9;
      b = 0;
      while (!out_valid[0] && b < 100) begin
         @(negedge clk);
         b++;
      end
      check("hold_wait", 64'(out_valid[0]), 1);
      model(1'b0, 16'd40001, er, em);
      repeat (20) begin
         check("hold_root", get_root(1'b0), er);
         check("hold_rem", get_rem(1'b0), em);
         check("hold_tag", get_tag(1'b0), 3);
         check("hold_valid", 64'(out_valid[0]), 1);
         check("hold_ready", 64'(in_ready[0]), 0);
         @(negedge clk);
      end
      out_ready[0] = 1'b1;
      #1;
      check("drain_ready", 64'(in_ready[0]), 1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      check("drain_busy", 64'(busy[0]), 1);
      check("drain_valid", 64'(out_valid[0]), 0);
      wait_result(1'b0, lat);
      model(1'b0, 16'd50, er, em);
      check("next_lat", 64'(lat), 10);
      check("next_root", get_root(1'b0), er);
      check("next_rem", get_rem(1'b0), em);
      check("next_tag", get_tag(1'b0), 9);

      // Reset during the 4th RUN cycle aborts the operation
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data     = 16'd1000;
      in_tag      = 4'd12;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy[0]), 0);
      check("abort_valid", 64'(out_valid[0]), 0);
      check("abort_ready", 64'(in_ready[0]), 0);
      check("abort_root", get_root(1'b0), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_ready_rise", 64'(in_ready[0]), 1);
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid[0]) seen++;
      end
      check("abort_no_result", 64'(seen), 0);
      run_op(1'b0, 16'd1000, 4'd11, lat);
      model(1'b0, 16'd1000, er, em);
      check("post_rst_lat", 64'(lat), 10);
      check("post_rst_root", get_root(1'b0), er);
      check("post_rst_rem", get_rem(1'b0), em);
      check("post_rst_tag", get_tag(1'b0), 11);

      // Randomized sweeps with corner radicands first and random back-pressure
      stim = '{16'd0, 16'd1, 16'd2, 16'd3, 16'hFFFF, 16'hFFFE, 16'd16384, 16'd255, 16'd256};
      stream(1'b0, 1500, 1'b1, gap);
      stim = '{16'd0, 16'd1, 16'd2, 16'hFFFF, 16'hFFFE};
      stream(1'b1, 300, 1'b1, gap);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
